tlk2711_rx_deframer: RTL and testbench

//  Consumes the TLK2711 parallel receive bus (16-bit rxd + rkmsb/rklsb K-flags) in the rx_clk domain.

---
 rtl/tlk2711_pkg.sv | 52 +++++
 rtl/crc16_ccitt_w16.sv | 27 ++
 rtl/tlk2711_rx_deframer.sv | 187 ++++++++++++++++++
 tb/tb_tlk2711_rx_deframer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg -- shared definitions for the TLK2711 receive deframer and transmit framer.
//   K-code words and flag pairs, FSM state encoding, received-word classes,
//   frame error bit indices, CRC16-CCITT polynomial/seed and a one-word CRC step.
package tlk2711_pkg;

  localparam logic [15:0] K_IDLE_WORD  = 16'hC5BC;
  localparam logic [15:0] K_SOF_WORD   = 16'hFBFB;
  localparam logic [15:0] K_EOF_WORD   = 16'hFDFD;
  localparam logic [15:0] K_ERR_WORD   = 16'hFEFE;
  localparam logic [1:0]  K_DATA_FLAGS = 2'b00;
  localparam logic [1:0]  K_IDLE_FLAGS = 2'b01;
  localparam logic [1:0]  K_CTRL_FLAGS = 2'b11;

  localparam int ERR_LEN   = 0;
  localparam int ERR_CRC   = 1;
  localparam int ERR_ABORT = 2;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_UNSYNC, ST_IDLE, ST_HDR, ST_PAYLOAD, ST_CRC, ST_EOFCHK
  } state_t;

  typedef enum logic [2:0] {
    W_DATA, W_IDLE, W_SOF, W_EOF, W_ERR, W_INV
  } word_t;

  // k = {rkmsb, rklsb}
  function automatic word_t classify(input logic [1:0] k, input logic [15:0] d);
    word_t w;
    w = W_INV;
    if (k == K_DATA_FLAGS) w = W_DATA;
    else if (k == K_IDLE_FLAGS && d == K_IDLE_WORD) w = W_IDLE;
    else if (k == K_CTRL_FLAGS) begin
      if (d == K_SOF_WORD)      w = W_SOF;
      else if (d == K_EOF_WORD) w = W_EOF;
      else if (d == K_ERR_WORD) w = W_ERR;
    end
    return w;
  endfunction

  // CRC16-CCITT over one 16-bit word, MSB first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? CRC_POLY : 16'h0000);
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt_w16.sv
// crc16_ccitt_w16 -- running CRC16-CCITT, one 16-bit word per cycle.
//   clk, rstn : clock, async active-low reset
//   clr       : reload the seed (wins over en)
//   en        : fold data into the CRC
//   data      : input word
//   crc       : current CRC register
// Only built when TLK_RX_CRC_EN is defined; without it the deframer carries no CRC.
`ifdef TLK_RX_CRC_EN
module crc16_ccitt_w16
  import tlk2711_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc16_step(crc, data);
  end

endmodule
`endif

// File: rtl/tlk2711_rx_deframer.sv
// tlk2711_rx_deframer -- TLK2711 receive deframer.
//   Acquires sync on IDLE commas, delimits SOF/HDR/payload/[CRC]/EOF frames,
//   streams payload valid-only and reports per-frame status and counters.
//   clk, rstn           : rx word clock, async active-low reset
//   i_rxd, i_rkmsb/lsb  : received word and K flags
//   o_sync              : link synchronised
//   o_tdata/tvalid/tlast: payload stream, no backpressure
//   o_frame_done/err    : 1-cycle frame termination pulse, {abort, crc, len/eof}
//   o_frame_cnt/err_cnt : good frames (wraps), errored frames (saturates)
// Build option: TLK_RX_CRC_EN adds a CRC16-CCITT word after the payload.
module tlk2711_rx_deframer
  import tlk2711_pkg::*;
#(
  parameter int MAX_LEN    = 1024,
  parameter int SYNC_IDLES = 16,
  parameter int LOS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] i_rxd,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  output logic        o_sync,
  output logic [15:0] o_tdata,
  output logic        o_tvalid,
  output logic        o_tlast,
  output logic        o_frame_done,
  output logic [2:0]  o_frame_err,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(SYNC_IDLES + 1);
  localparam int VW = $clog2(LOS_THRESH + 1);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  logic [15:0]   rxd;
  logic [1:0]    rk;
  word_t         wt;
  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [VW-1:0] los_cnt;
  logic [LW-1:0] len_m1, cnt;
  logic          crc_bad;
  logic          in_frame, los, abort;

  // single input register stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd <= '0;
      rk  <= '0;
    end else begin
      rxd <= i_rxd;
      rk  <= {i_rkmsb, i_rklsb};
    end
  end

  assign wt       = classify(rk, rxd);
  assign in_frame = state inside {ST_HDR, ST_PAYLOAD, ST_CRC, ST_EOFCHK};
  assign los      = (wt == W_INV) && (los_cnt == VW'(LOS_THRESH - 1)) && (state != ST_UNSYNC);
  // any K word inside a frame truncates it, except the EOF that closes it
  assign abort    = in_frame && (wt != W_DATA) && !(state == ST_EOFCHK && wt == W_EOF);

`ifdef TLK_RX_CRC_EN
  logic [15:0] crc;
  crc16_ccitt_w16 u_crc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (wt == W_SOF && (state == ST_IDLE || in_frame)),
    .en   (wt == W_DATA && (state == ST_HDR || state == ST_PAYLOAD)),
    .data (rxd),
    .crc  (crc)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_UNSYNC;
      idle_cnt     <= '0;
      los_cnt      <= '0;
      len_m1       <= '0;
      cnt          <= '0;
      crc_bad      <= 1'b0;
      o_sync       <= 1'b0;
      o_tdata      <= '0;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= '0;
    end else begin
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= '0;
      los_cnt      <= (wt == W_INV && !los) ? los_cnt + VW'(1) : '0;

      if (los) begin
        state    <= ST_UNSYNC;
        o_sync   <= 1'b0;
        idle_cnt <= '0;
        if (in_frame) begin
          o_frame_done <= 1'b1;
          o_frame_err  <= {1'b1, crc_bad, 1'b0};
        end
      end else if (abort) begin
        o_frame_done <= 1'b1;
        o_frame_err  <= {1'b1, crc_bad, 1'b0};
        state        <= (wt == W_SOF) ? ST_HDR : ST_IDLE;
        cnt          <= '0;
        crc_bad      <= 1'b0;
      end else begin
        case (state)
          ST_UNSYNC: begin
            if (wt == W_IDLE) begin
              if (idle_cnt == IW'(SYNC_IDLES - 1)) begin
                state    <= ST_IDLE;
                o_sync   <= 1'b1;
                idle_cnt <= '0;
              end else begin
                idle_cnt <= idle_cnt + IW'(1);
              end
            end else begin
              idle_cnt <= '0;
            end
          end
          ST_IDLE: begin
            if (wt == W_SOF) begin
              state   <= ST_HDR;
              cnt     <= '0;
              crc_bad <= 1'b0;
            end
          end
          ST_HDR: begin
            if (rxd == 16'h0000 || rxd > MAX_LEN16) begin
              o_frame_done <= 1'b1;
              o_frame_err  <= 3'b001;
              state        <= ST_IDLE;
            end else begin
              len_m1 <= LW'(rxd - 16'd1);
              state  <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            o_tvalid <= 1'b1;
            o_tdata  <= rxd;
            if (cnt == len_m1) begin
              o_tlast <= 1'b1;
`ifdef TLK_RX_CRC_EN
              state   <= ST_CRC;
`else
              state   <= ST_EOFCHK;
`endif
            end else begin
              cnt <= cnt + LW'(1);
            end
          end
`ifdef TLK_RX_CRC_EN
          ST_CRC: begin
            if (rxd != crc) crc_bad <= 1'b1;
            state <= ST_EOFCHK;
          end
`endif
          ST_EOFCHK: begin
            o_frame_done <= 1'b1;
            // only data words reach here besides EOF; they mean a missing EOF
            o_frame_err  <= {1'b0, crc_bad, (wt != W_EOF)};
            state        <= ST_IDLE;
          end
          default: state <= ST_UNSYNC;
        endcase
      end
    end
  end

  // statistics follow the done pulse by one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else if (o_frame_done) begin
      if (o_frame_err == 3'b000)    o_frame_cnt <= o_frame_cnt + 32'd1;
      else if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// tb_tlk2711_rx_deframer -- scoreboard bench for tlk2711_rx_deframer.
//   Stimulus pushes expected beats/done pulses; a negedge monitor pops and compares.
//   Honours TLK_RX_CRC_EN the same way as the design.
module tb_tlk2711_rx_deframer;

  localparam logic [1:0]  KD = 2'b00, KI = 2'b01, KC = 2'b11, KX = 2'b10;
  localparam logic [15:0] IDLEW = 16'hC5BC, SOFW = 16'hFBFB, EOFW = 16'hFDFD, ERRW = 16'hFEFE;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] i_rxd = '0;
  logic        i_rkmsb = 1'b0, i_rklsb = 1'b0;
  logic        o_sync, o_tvalid, o_tlast, o_frame_done;
  logic [15:0] o_tdata, o_err_cnt;
  logic [2:0]  o_frame_err;
  logic [31:0] o_frame_cnt;

  tlk2711_rx_deframer dut (
    .clk(clk), .rstn(rstn), .i_rxd(i_rxd), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb),
    .o_sync(o_sync), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
    .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done;
    logic [15:0] data;
    bit          last;
    logic [2:0]  err;
  } ev_t;

  ev_t         sbq[$];
  int          checks = 0, errors = 0;
  int          exp_good = 0, exp_bad = 0;
  logic [15:0] q[$];

  function automatic logic [15:0] tb_crc(input logic [15:0] w[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (w[j])
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ w[j][b];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [1:0] k, input logic [15:0] d);
    @(negedge clk);
    {i_rkmsb, i_rklsb} = k;
    i_rxd = d;
  endtask

  task automatic idles(input int n);
    repeat (n) put(KI, IDLEW);
  endtask

  task automatic push_beat(input logic [15:0] d, input bit last);
    ev_t e;
    e.done = 1'b0; e.data = d; e.last = last; e.err = '0;
    sbq.push_back(e);
  endtask

  task automatic push_done(input logic [2:0] err);
    ev_t e;
    e.done = 1'b1; e.data = '0; e.last = 1'b0; e.err = err;
    sbq.push_back(e);
    if (err == 3'b000) exp_good++; else exp_bad++;
  endtask

  // SOF, HDR=n, words in q (last optionally bit-flipped on the wire), [CRC over
  // the unflipped words], then EOF or an IDLE in its place
  task automatic frame(input logic [15:0] n, input bit flip, input bit eof, input logic [2:0] err);
    logic [15:0] cw[$];
    logic [15:0] d;
    cw.push_back(n);
    put(KC, SOFW);
    put(KD, n);
    foreach (q[i]) begin
      d = q[i];
      if (flip && i == q.size() - 1) d[0] = ~d[0];
      put(KD, d);
      push_beat(d, i == q.size() - 1);
      cw.push_back(q[i]);
    end
`ifdef TLK_RX_CRC_EN
    put(KD, tb_crc(cw));
`endif
    if (eof) put(KC, EOFW); else put(KI, IDLEW);
    push_done(err);
    idles(4);
  endtask

  task automatic check_cnts();
    check("frame_cnt", o_frame_cnt, exp_good);
    check("err_cnt", {16'h0, o_err_cnt}, exp_bad);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    ev_t e;
    if (o_tvalid || o_frame_done) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: tvalid=%0b done=%0b data=%h err=%b, nothing expected",
                 o_tvalid, o_frame_done, o_tdata, o_frame_err);
      end else begin
        e = sbq.pop_front();
        if (e.done) begin
          if (!o_frame_done || o_tvalid || o_frame_err !== e.err) begin
            errors++;
            $display("FAIL done: done=%0b tvalid=%0b err=%b, expected done err=%b",
                     o_frame_done, o_tvalid, o_frame_err, e.err);
          end
        end else if (!o_tvalid || o_frame_done || o_tdata !== e.data || o_tlast !== e.last) begin
          errors++;
          $display("FAIL beat: tvalid=%0b done=%0b data=%h last=%0b, expected data=%h last=%0b",
                   o_tvalid, o_frame_done, o_tdata, o_tlast, e.data, e.last);
        end
      end
    end
  end

  initial begin
    logic [15:0] cw[$];
    repeat (3) @(negedge clk);
    #1;
    check("rst_sync", {31'h0, o_sync}, 0);
    check("rst_outs", {o_tdata, 12'h0, o_tvalid, o_tlast, o_frame_done, 1'b0}, 0);
    check("rst_err", {29'h0, o_frame_err}, 0);
    check_cnts();
    @(negedge clk);
    rstn = 1'b1;

    // sync acquisition: 16th IDLE processed on the 17th edge after the first drive
    for (int k = 1; k <= 20; k++) begin
      put(KI, IDLEW);
      if (k == 17) check("sync_early", {31'h0, o_sync}, 0);
      if (k == 18) check("sync_rise", {31'h0, o_sync}, 1);
    end

    // loss of sync
    repeat (3) put(KX, 16'h1234);
    idles(2);
    check("los_3", {31'h0, o_sync}, 1);
    repeat (4) put(KC, 16'h1234);
    idles(2);
    check("los_4", {31'h0, o_sync}, 0);
    idles(20);
    check("resync", {31'h0, o_sync}, 1);

    // basic frame
    q.delete(); q.push_back(16'h1111); q.push_back(16'h2222); q.push_back(16'h3333);
    frame(16'd3, 1'b0, 1'b1, 3'b000);
    check_cnts();

    // length errors
    put(KC, SOFW); put(KD, 16'd0); push_done(3'b001); idles(4);
    put(KC, SOFW); put(KD, 16'd1025); push_done(3'b001); idles(4);
    check_cnts();

    // ERR word mid-payload, then a clean frame
    put(KC, SOFW); put(KD, 16'd4);
    put(KD, 16'hAAAA); push_beat(16'hAAAA, 1'b0);
    put(KD, 16'hBBBB); push_beat(16'hBBBB, 1'b0);
    put(KC, ERRW); push_done(3'b100);
    idles(2);
    q.delete(); q.push_back(16'h0101); q.push_back(16'h0202);
    frame(16'd2, 1'b0, 1'b1, 3'b000);
    check_cnts();

    // last payload bit flipped: only the CRC build can see it
    q.delete(); q.push_back(16'h5A5A); q.push_back(16'h1234);
`ifdef TLK_RX_CRC_EN
    frame(16'd2, 1'b1, 1'b1, 3'b010);
`else
    frame(16'd2, 1'b1, 1'b1, 3'b000);
`endif
    check_cnts();

    // missing EOF
    q.delete(); q.push_back(16'h7777);
    frame(16'd1, 1'b0, 1'b0, 3'b100);
    check_cnts();

    // SOF mid-payload aborts and restarts the header
    put(KC, SOFW); put(KD, 16'd3);
    put(KD, 16'h0001); push_beat(16'h0001, 1'b0);
    put(KC, SOFW); push_done(3'b100);
    put(KD, 16'd1);
    put(KD, 16'h0009); push_beat(16'h0009, 1'b1);
    cw.push_back(16'd1); cw.push_back(16'h0009);
`ifdef TLK_RX_CRC_EN
    put(KD, tb_crc(cw));
`endif
    put(KC, EOFW); push_done(3'b000);
    idles(4);
    check_cnts();

    // maximum length accepted
    q.delete();
    for (int i = 0; i < 1024; i++) q.push_back(16'(i * 3 + 1));
    frame(16'd1024, 1'b0, 1'b1, 3'b000);
    check_cnts();

    // reset mid-payload: D1, D2 emerge, D3 is cut off
    put(KC, SOFW); put(KD, 16'd4);
    put(KD, 16'h00D1); push_beat(16'h00D1, 1'b0);
    put(KD, 16'h00D2); push_beat(16'h00D2, 1'b0);
    put(KD, 16'h00D3);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_sync", {31'h0, o_sync}, 0);
    check("mid_rst_outs", {o_tdata, 12'h0, o_tvalid, o_tlast, o_frame_done, 1'b0}, 0);
    exp_good = 0; exp_bad = 0;
    check_cnts();
    @(negedge clk);
    rstn = 1'b1;
    idles(4);
    check("sbq_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
